pwm_duty_ctrl: RTL
==================

Name: pwm_duty_ctrl

Overview:
Parametrised duty-cycle controller for the DPWM datapath, the next generation of the push-button duty state machine. It synchronises up and down push-buttons and steps a duty register by a configurable amount. Holding a button auto-repeats. At the limits the register either wraps or saturates. Its output feeds the PWM comparator, or an optional built-in PWM generator.

Parameters:
WIDTH, 10, duty register width in bits.
MAX_DUTY, 1000, upper duty limit. Must be < 2**WIDTH.
STEP, 1, increment/decrement amount. 1 <= STEP <= MAX_DUTY.
WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits.
REPEAT_DELAY, 5000000, hold cycles before auto-repeat starts. Must be >= 1.
REPEAT_RATE, 1000000, cycles between auto-repeat steps. Must be >= 1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset. 0 resets all state.
btn_up  in  1  raw up button, asynchronous, already debounced.
btn_down  in  1  raw down button, asynchronous, already debounced.
duty  out  WIDTH  current duty value, registered.
step_pulse  out  1  one-cycle pulse, high in the cycle after each duty update.
at_max  out  1  high when duty == MAX_DUTY (decoded from the duty register).
at_min  out  1  high when duty == 0.
pwm_out  out  1  PWM output (see Optional Feature).

Behaviour:
- Reset (reset=0), all asynchronous:
  - duty=0, step_pulse=0, pwm_out=0.
  - Synchroniser and edge flops cleared; FSM returns to IDLE; repeat counter cleared.
- Input path:
  - Two-flop synchroniser per button, then a registered previous-value flop for edge detection.
  - press_up = up_s & ~up_prev & ~down_s; press_down is symmetric.
- Latency:
  - A button asserted before edge n gives its duty update at edge n+2, and step_pulse in the following cycle.
- FSM states:
  - IDLE: on press_up or press_down, apply one step, clear the counter, go HOLD. Otherwise stay.
  - HOLD: held button released, or both buttons high -> IDLE with no step. Counter == REPEAT_DELAY-1 -> apply step, clear counter, go REPEAT. Else counter++.
  - REPEAT: release or both buttons high -> IDLE. Counter == REPEAT_RATE-1 -> apply step, clear counter. Else counter++.
  - Illegal state encoding -> IDLE.
- Simultaneous events:
  - Both buttons rising in the same cycle: no step, stay IDLE.
  - Second button pressed during HOLD or REPEAT: abort to IDLE with no step. A new press is needed after both buttons are released.
- Step arithmetic, computed at WIDTH+1 bits:
  - Up: if duty+STEP > MAX_DUTY, result is 0 when WRAP=1 and MAX_DUTY when WRAP=0. Otherwise duty+STEP.
  - Down: if duty < STEP, result is MAX_DUTY when WRAP=1 and 0 when WRAP=0. Otherwise duty-STEP.
- step_pulse:
  - Asserted for every applied step, including a step that saturates with no change in value.
- Counter:
  - Width is $clog2 of max(REPEAT_DELAY, REPEAT_RATE), plus 1 bit.
  - Cleared on every entry to HOLD and on every REPEAT step.
- Reset mid-operation:
  - Aborts the hold immediately.
  - A button still held at reset release is seen as a new rising edge and produces exactly one step.

Optional Feature:
- Macro: PWM_DUTY_CTRL_PWMGEN_EN.
- Defined:
  - Adds a free-running period counter 0..MAX_DUTY-1 and a shadow duty register. The shadow loads duty only when the counter is 0, so there are no mid-period glitches.
  - pwm_out is registered and equals (counter < shadow).
  - duty=0 gives a constant 0; duty=MAX_DUTY gives a constant 1.
- Undefined:
  - No period counter and no shadow register are built.
  - pwm_out is tied to 0.

Test Plan:
All scenarios use WIDTH=10, MAX_DUTY=1000, STEP=1, REPEAT_DELAY=8, REPEAT_RATE=4 unless stated.
1. Reset, then a 1-cycle btn_up pulse -> duty 0->1 at edge n+2, step_pulse high for 1 cycle, no further change.
2. WRAP=1: duty=1000, press up -> duty=0, at_min=1. Then press down -> duty=1000, at_max=1.
3. WRAP=0: duty=1000, press up -> duty stays 1000 with step_pulse=1. duty=0, press down -> duty stays 0.
4. Hold btn_up for 30 cycles from duty=10 -> one step at press, next step 8 cycles later, then one every 4 cycles. Release -> IDLE; final duty matches the count of step_pulse pulses.
5. Both buttons rising in the same cycle -> no step. During a btn_up hold, assert btn_down -> FSM goes IDLE, no more steps.
6. With PWM_DUTY_CTRL_PWMGEN_EN, duty=250 -> pwm_out high for 250 of every 1000 cycles. Change duty mid-period -> new width takes effect from the next period. Without the macro -> pwm_out=0 always.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_ctrl
// Purpose  : Push-button duty-cycle controller for the DPWM datapath.
//            Synchronises the up/down buttons and steps a duty register by
//            STEP. Holding a button auto-repeats: the first repeat comes after
//            REPEAT_DELAY cycles, and later repeats every REPEAT_RATE cycles.
//            At the limits the register wraps (WRAP=1) or saturates (WRAP=0).
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            btn_up     - raw up button (asynchronous, already debounced)
//            btn_down   - raw down button (asynchronous, already debounced)
//            duty       - registered duty value [WIDTH-1:0]
//            step_pulse - high for one cycle after each applied step
//            at_max     - duty == MAX_DUTY
//            at_min     - duty == 0
//            pwm_out    - PWM output (0 unless the generator is built)
// Options  : define PWM_DUTY_CTRL_PWMGEN_EN to build the internal PWM
//            generator (period counter 0..MAX_DUTY-1 plus a shadow duty
//            register). When it is not defined, pwm_out is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl #(
  parameter int WIDTH        = 10,
  parameter int MAX_DUTY     = 1000,
  parameter int STEP         = 1,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [WIDTH-1:0] duty,
  output logic             step_pulse,
  output logic             at_max,
  output logic             at_min,
  output logic             pwm_out
);

  localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

  localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  localparam logic [WIDTH:0]   c_step_ext = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   c_max_ext  = (WIDTH+1)'(MAX_DUTY);
  localparam logic [WIDTH-1:0] c_max      = WIDTH'(MAX_DUTY);
  localparam logic [WIDTH-1:0] c_step     = WIDTH'(STEP);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_hold   = 2'd1;
  localparam logic [1:0] c_st_repeat = 2'd2;

  // --------------------------------------------------------------------------
  // Input path: two-flop synchroniser, then a previous-value flop for edges
  // --------------------------------------------------------------------------
  logic r_up_meta, r_up_sync, r_up_prev;
  logic r_dn_meta, r_dn_sync, r_dn_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_meta <= 1'b0;
      r_up_sync <= 1'b0;
      r_up_prev <= 1'b0;
      r_dn_meta <= 1'b0;
      r_dn_sync <= 1'b0;
      r_dn_prev <= 1'b0;
    end else begin
      r_up_meta <= btn_up;
      r_up_sync <= r_up_meta;
      r_up_prev <= r_up_sync;
      r_dn_meta <= btn_down;
      r_dn_sync <= r_dn_meta;
      r_dn_prev <= r_dn_sync;
    end
  end

  // A press only counts while the other button is released, so two buttons
  // rising together never produce a step.
  logic w_press_up, w_press_dn;
  assign w_press_up = r_up_sync & ~r_up_prev & ~r_dn_sync;
  assign w_press_dn = r_dn_sync & ~r_dn_prev & ~r_up_sync;

  // --------------------------------------------------------------------------
  // Step arithmetic at WIDTH+1 bits so the overflow check cannot alias
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_duty_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;

  assign w_duty_ext = {1'b0, duty};
  assign w_sum      = w_duty_ext + c_step_ext;
  assign w_diff     = duty - c_step;

  always_comb begin
    w_up_val = w_sum[WIDTH-1:0];
    if (w_sum > c_max_ext) begin
      w_up_val = (WRAP != 0) ? '0 : c_max;
    end
    w_dn_val = w_diff;
    if (w_duty_ext < c_step_ext) begin
      w_dn_val = (WRAP != 0) ? c_max : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Hold / auto-repeat FSM
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_dir_up;
  logic               w_dir_up_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_step;
  logic               w_abort;

  // The hold ends when the held button is released or the other one joins.
  assign w_abort = (r_dir_up ? ~r_up_sync : ~r_dn_sync) | (r_up_sync & r_dn_sync);

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_up_nxt = r_dir_up;
    w_cnt_nxt    = r_cnt;
    w_step       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_press_up || w_press_dn) begin
          w_step       = 1'b1;
          w_dir_up_nxt = w_press_up;
          w_cnt_nxt    = '0;
          w_state_nxt  = c_st_hold;
        end
      end
      c_st_hold: begin
        if (w_abort) begin
          w_cnt_nxt   = '0;
          w_state_nxt = c_st_idle;
        end else if (r_cnt == c_delay_last) begin
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = c_st_repeat;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      c_st_repeat: begin
        if (w_abort) begin
          w_cnt_nxt   = '0;
          w_state_nxt = c_st_idle;
        end else if (r_cnt == c_rate_last) begin
          w_step    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // In IDLE the direction comes from the press itself; afterwards it is the
  // latched direction of the held button.
  logic w_step_up;
  assign w_step_up = (r_state == c_st_idle) ? w_press_up : r_dir_up;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_dir_up   <= 1'b0;
      r_cnt      <= '0;
      duty       <= '0;
      step_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_up   <= w_dir_up_nxt;
      r_cnt      <= w_cnt_nxt;
      step_pulse <= w_step;
      if (w_step) begin
        duty <= w_step_up ? w_up_val : w_dn_val;
      end
    end
  end

  assign at_max = (duty == c_max);
  assign at_min = (duty == '0);

  // --------------------------------------------------------------------------
  // Optional PWM generator
  // --------------------------------------------------------------------------
`ifdef PWM_DUTY_CTRL_PWMGEN_EN
  localparam logic [WIDTH-1:0] c_period_last = WIDTH'(MAX_DUTY - 1);
  localparam logic [WIDTH-1:0] c_period_one  = WIDTH'(1);

  logic [WIDTH-1:0] r_period_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_cur;
  logic             r_pwm;

  // The shadow is refreshed at count 0; the compare at count 0 must already
  // use the freshly loaded value so every period uses a single duty.
  assign w_shadow_cur = (r_period_cnt == '0) ? duty : r_shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period_cnt <= '0;
      r_shadow     <= '0;
      r_pwm        <= 1'b0;
    end else begin
      if (r_period_cnt == c_period_last) begin
        r_period_cnt <= '0;
      end else begin
        r_period_cnt <= r_period_cnt + c_period_one;
      end
      r_shadow <= w_shadow_cur;
      r_pwm    <= (r_period_cnt < w_shadow_cur);
    end
  end

  assign pwm_out = r_pwm;
`else
  assign pwm_out = 1'b0;
`endif

endmodule
`default_nettype wire
